// File: rtl/y_res_seq.sv
// y_res_seq: tile sequencer for the y_res residual-add stage.
// Joins y-scan / xD completion pulses, issues one y_res start per head tile.
// Ports: clk, rst (sync, active-high), frame_start, y_done, xd_done,
//   res_done in; res_start, tile_idx, head_base, busy, frame_done,
//   err_overrun, err_timeout out. All outputs registered.
// Optional watchdog: define Y_RES_SEQ_TIMEOUT_EN to abort a frame when
//   y_res does not answer within TIMEOUT_CYC cycles of RUN.
module y_res_seq #(
  parameter int H           = 4,
  parameter int H_TILE      = 1,
  parameter int TIMEOUT_CYC = 1023,
  parameter int IW          = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_start,
  input  logic          y_done,
  input  logic          xd_done,
  input  logic          res_done,
  output logic          res_start,
  output logic [IW-1:0] tile_idx,
  output logic [IW-1:0] head_base,
  output logic          busy,
  output logic          frame_done,
  output logic          err_overrun,
  output logic          err_timeout
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int NT = H / H_TILE;
  localparam logic [IW-1:0] LAST = IW'(NT - 1);

  if ((H % H_TILE) != 0 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("y_res_seq: H must be a multiple of H_TILE, TIMEOUT_CYC >= 1");
  end

  logic [2:0] state;
  logic [2:0] state_n;
  logic       y_seen;
  logic       xd_seen;
  logic       y_have;
  logic       xd_have;
  logic       last_tile;
  logic       timeout_hit;

  // A pulse arriving in the join cycle counts toward the join.
  assign y_have    = y_seen | y_done;
  assign xd_have   = xd_seen | xd_done;
  assign last_tile = (tile_idx == LAST);

`ifdef Y_RES_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] wd_cnt;

  // res_done wins over the watchdog in the same cycle.
  assign timeout_hit = (state == S_RUN) && !res_done &&
                       (wd_cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (state == S_ISSUE)
        wd_cnt <= '0;
      else if (state == S_RUN)
        wd_cnt <= wd_cnt + CW'(1);
      if (state == S_IDLE && frame_start)
        err_timeout <= 1'b0;
      else if (timeout_hit)
        err_timeout <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (frame_start) state_n = S_WAIT;
      S_WAIT:  if (y_have && xd_have) state_n = S_ISSUE;
      S_ISSUE: state_n = S_RUN;
      S_RUN: begin
        if (res_done)
          state_n = last_tile ? S_DONE : S_WAIT;
        else if (timeout_hit)
          state_n = S_DONE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      y_seen      <= 1'b0;
      xd_seen     <= 1'b0;
      tile_idx    <= '0;
      head_base   <= '0;
      res_start   <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      state      <= state_n;
      res_start  <= (state_n == S_ISSUE);
      busy       <= (state_n != S_IDLE);
      frame_done <= (state_n == S_DONE);

      case (state)
        S_IDLE: begin
          if (frame_start) begin
            y_seen      <= 1'b0;
            xd_seen     <= 1'b0;
            tile_idx    <= '0;
            head_base   <= '0;
            err_overrun <= 1'b0;
          end
        end
        // Flags are consumed here; a pulse this cycle belongs
        // to the next tile, so it is neither dropped nor an overrun.
        S_ISSUE: begin
          y_seen  <= y_done;
          xd_seen <= xd_done;
        end
        default: begin
          if (y_done) begin
            if (y_seen) err_overrun <= 1'b1;
            else        y_seen      <= 1'b1;
          end
          if (xd_done) begin
            if (xd_seen) err_overrun <= 1'b1;
            else         xd_seen     <= 1'b1;
          end
        end
      endcase

      if (state == S_RUN && res_done && !last_tile) begin
        tile_idx  <= tile_idx + IW'(1);
        head_base <= head_base + IW'(H_TILE);
      end
    end
  end

endmodule

// File: tb/tb_y_res_seq.sv
// tb_y_res_seq: directed bench for y_res_seq.
// Instance a: H=4 H_TILE=1; instance b: H=4 H_TILE=2.
module tb_y_res_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       fs = 1'b0, y = 1'b0, xd = 1'b0, rd = 1'b0;
  logic       b_fs = 1'b0, b_y = 1'b0, b_xd = 1'b0, b_rd = 1'b0;

  logic       rs, bsy, fd, eo, et;
  logic [9:0] ti, hb;
  logic       b_rs, b_bsy, b_fd, b_eo, b_et;
  logic [9:0] b_ti, b_hb;

  int n_tests = 0;
  int n_fail  = 0;
  int n_start = 0;
  int n_fd    = 0;

  always #5 clk = ~clk;

  y_res_seq #(.H(4), .H_TILE(1), .TIMEOUT_CYC(20), .IW(10)) u_a (
    .clk(clk), .rst(rst), .frame_start(fs), .y_done(y),
    .xd_done(xd), .res_done(rd), .res_start(rs), .tile_idx(ti),
    .head_base(hb), .busy(bsy), .frame_done(fd),
    .err_overrun(eo), .err_timeout(et)
  );

  y_res_seq #(.H(4), .H_TILE(2), .TIMEOUT_CYC(20), .IW(10)) u_b (
    .clk(clk), .rst(rst), .frame_start(b_fs), .y_done(b_y),
    .xd_done(b_xd), .res_done(b_rd), .res_start(b_rs),
    .tile_idx(b_ti), .head_base(b_hb), .busy(b_bsy),
    .frame_done(b_fd), .err_overrun(b_eo), .err_timeout(b_et)
  );

  always @(negedge clk) begin
    if (rs) n_start++;
    if (fd) n_fd++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fstart();
    fs = 1'b1; tick(); fs = 1'b0;
  endtask

  task automatic both();
    y = 1'b1; xd = 1'b1; tick(); y = 1'b0; xd = 1'b0;
  endtask

  task automatic rdone();
    rd = 1'b1; tick(); rd = 1'b0;
  endtask

  // Both producers together, then a 13-cycle y_res.
  task automatic tile_sim(input int t);
    both();
    chk($sformatf("start_t%0d", t), int'(rs), 1);
    chk($sformatf("tile_t%0d", t), int'(ti), t);
    repeat (12) tick();
    rdone();
  endtask

  int k;
  int n;

  initial begin
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    chk("rst_start", int'(rs), 0);
    chk("rst_busy", int'(bsy), 0);
    chk("rst_fd", int'(fd), 0);
    chk("rst_eo", int'(eo), 0);
    chk("rst_et", int'(et), 0);
    chk("rst_tile", int'(ti), 0);
    chk("rst_hb", int'(hb), 0);

    // Simultaneous arrival
    both();
    chk("idle_ignore", int'(bsy), 0);
    fstart();
    chk("fs_busy", int'(bsy), 1);
    for (int t = 0; t < 4; t++) begin
      tile_sim(t);
      if (t < 3) chk($sformatf("mid_fd_t%0d", t), int'(fd), 0);
    end
    chk("sim_fd", int'(fd), 1);
    tick();
    chk("sim_fd_pulse", int'(fd), 0);
    chk("sim_idle", int'(bsy), 0);
    chk("sim_nstart", n_start, 4);
    chk("sim_eo", int'(eo), 0);

    // Staggered arrival: y at cycle 5, xd at cycle 40
    fstart();
    repeat (4) tick();
    y = 1'b1; tick(); y = 1'b0;
    k = n_start;
    repeat (34) tick();
    chk("stag_early", n_start - k, 0);
    xd = 1'b1; tick(); xd = 1'b0;
    chk("stag_start", int'(rs), 1);
    chk("stag_hb", int'(hb), 0);

    // Prefetch of tile 1 during RUN of tile 0
    tick();
    chk("issue_1cyc", int'(rs), 0);
    y = 1'b1; tick(); y = 1'b0;
    tick();
    xd = 1'b1; tick(); xd = 1'b0;
    repeat (5) tick();
    rdone();
    chk("pf_r1_start", int'(rs), 0);
    chk("pf_r1_busy", int'(bsy), 1);
    tick();
    chk("pf_r2_start", int'(rs), 1);
    chk("pf_tile", int'(ti), 1);
    repeat (12) tick();
    rdone();
    tile_sim(2);
    tile_sim(3);
    chk("stag_fd", int'(fd), 1);
    tick();

    // Overrun
    fstart();
    y = 1'b1; tick(); y = 1'b0;
    tick();
    y = 1'b1; tick(); y = 1'b0;
    chk("ovr_flag", int'(eo), 1);
    chk("ovr_nostart", int'(rs), 0);
    k = n_start;
    xd = 1'b1; tick(); xd = 1'b0;
    chk("ovr_start", int'(rs), 1);
    repeat (12) tick();
    chk("ovr_one", n_start - k, 1);
    rdone();
    for (int t = 1; t < 4; t++) tile_sim(t);
    chk("ovr_fd", int'(fd), 1);
    tick();
    chk("ovr_sticky", int'(eo), 1);
    fstart();
    chk("ovr_clear", int'(eo), 0);

    // Reset during RUN of tile 2
    tile_sim(0);
    tile_sim(1);
    both();
    chk("rr_tile", int'(ti), 2);
    tick();
    tick();
    k = n_fd;
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rr_busy", int'(bsy), 0);
    chk("rr_start", int'(rs), 0);
    chk("rr_tile0", int'(ti), 0);
    chk("rr_hb0", int'(hb), 0);
    chk("rr_eo", int'(eo), 0);
    repeat (3) tick();
    rdone();
    repeat (3) tick();
    chk("rr_nofd", n_fd - k, 0);
    chk("rr_idle", int'(bsy), 0);

    // H_TILE=2 frame
    b_fs = 1'b1; tick(); b_fs = 1'b0;
    b_y = 1'b1; b_xd = 1'b1; tick(); b_y = 1'b0; b_xd = 1'b0;
    chk("ht2_start0", int'(b_rs), 1);
    chk("ht2_hb0", int'(b_hb), 0);
    repeat (6) tick();
    b_rd = 1'b1; tick(); b_rd = 1'b0;
    b_y = 1'b1; b_xd = 1'b1; tick(); b_y = 1'b0; b_xd = 1'b0;
    chk("ht2_start1", int'(b_rs), 1);
    chk("ht2_hb1", int'(b_hb), 2);
    chk("ht2_tile1", int'(b_ti), 1);
    repeat (6) tick();
    b_rd = 1'b1; tick(); b_rd = 1'b0;
    chk("ht2_fd", int'(b_fd), 1);
    chk("ht2_eo", int'(b_eo), 0);

`ifdef Y_RES_SEQ_TIMEOUT_EN
    fstart();
    both();
    chk("to_start", int'(rs), 1);
    n = 0;
    while (!fd && n < 60) begin
      tick();
      n++;
    end
    chk("to_latency", n, 21);
    chk("to_flag", int'(et), 1);
    tick();
    chk("to_idle", int'(bsy), 0);
`else
    chk("no_timeout", int'(et), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench hung");
  end

endmodule
